sqrt_iter_unit: RTL
===================

// Module: sqrt_iter_unit
// PURPOSE
//  Parametrised iterative integer square root with start/valid handshake; successor to the
//  odd-subtraction square-root engine. Uses the digit-by-digit (bit-pair) method: one root bit
//  per cycle, so latency is fixed at WIDTH/2 cycles instead of data-dependent.
//  Returns root = floor(sqrt(radicand_i)) and rem = radicand - root^2.
//  Sits as a slave arithmetic unit beside the datapath; the host launches with start_i.
// PARAMETERS
//  WIDTH    16   radicand width; must be even and >= 2 (elaboration error otherwise)
//  RW       WIDTH/2 (localparam)   root width
//  CW       $clog2(WIDTH/2)+1 (localparam)   iteration counter width
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  start_i      in   1        launch request; accepted only when ready_o=1
//  abort_i      in   1        synchronous cancel of the operation in flight
//  radicand_i   in   WIDTH    operand; sampled on the accepting edge only
//  ready_o      out  1        unit can accept start_i (state IDLE or DONE)
//  busy_o       out  1        iteration in progress (state CALC)
//  valid_o      out  1        one-cycle pulse: root_o/rem_o hold a fresh result
//  root_o       out  RW       square root
//  rem_o        out  RW+1     remainder; always <= 2*root_o
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ready_o=1, busy_o=0, valid_o=0, root_o=0, rem_o=0,
//   operand shift register=0, counter=0. Reset mid-CALC discards the operation; no valid_o.
//  FSM (3 states): IDLE -> CALC on start_i; CALC -> CALC while cnt!=0; CALC -> DONE when cnt==0;
//   DONE -> IDLE unconditionally, or DONE -> CALC when start_i=1 (back-to-back).
//   abort_i in CALC -> IDLE, valid_o never asserted for that op. abort_i ignored in IDLE/DONE.
//   abort_i and start_i together in DONE: start wins (abort has nothing to cancel).
//  Accept edge (ready_o & start_i): x <= radicand_i, root <= 0, rem <= 0, cnt <= RW-1.
//  Each CALC edge: r2 = {rem,x[WIDTH-1:WIDTH-2]} (RW+3 bits), t = {root,2'b01};
//   if r2 >= t: rem <= r2-t, root <= {root,1}; else rem <= r2, root <= {root,0};
//   x <= x<<2; cnt <= cnt-1. No truncation loss: intermediates held at RW+3 bits.
//  Latency: accept at edge 0, iterations at edges 1..RW, valid_o=1 for exactly the cycle after
//   edge RW (state DONE). Throughput: one result per RW+1 cycles when start_i held high.
//  start_i while busy_o=1: ignored, no queueing; radicand_i not sampled.
//  root_o/rem_o are the working registers: change during CALC; stable from DONE until the
//   next accept edge; both defined only when valid_o=1 or in IDLE after a completed op.
//  ready_o, busy_o, valid_o decoded from state only (no input-to-output combinational path).
//  Illegal state encodings recover to IDLE with all status outputs as in reset.
// STRUCTURE
//  Shared package sqrt_defs: FSM state encodings (IDLE/CALC/DONE), width-check macro.
//  One sub-module: sqrt_step -- combinational single iteration (rem,root,pair -> rem',root'),
//   parametrised by RW; sqrt_iter_unit holds FSM, counter, shift register and registers.
// TESTING
//  1 WIDTH=16, radicand 0 -> after 8 cycles valid_o pulse, root_o=0, rem_o=0.
//  2 WIDTH=16, 144 -> root 12 rem 0; 143 -> root 11 rem 22; 65535 -> root 255 rem 510.
//  3 start_i held high across DONE with 100 then 99 -> valid pulses 9 cycles apart: (10,0),(9,18).
//  4 start_i pulsed during CALC with new operand -> ignored; first result unchanged, one valid.
//  5 abort_i at 4th CALC cycle -> IDLE next edge, ready_o=1, no valid_o; rst_n low mid-CALC ->
//    all outputs reset values immediately (async).
//  6 WIDTH=8 instance: exhaustive 0..255 vs reference model; root^2+rem==radicand, rem<=2*root,
//    latency exactly 4 cycles each.

Source files
------------

// File: rtl/sqrt_defs.sv
// rtl/sqrt_defs.sv - shared FSM encodings and width check for the square-root unit
package sqrt_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic bit sqrt_width_ok(input int w);
    return (w >= 2) && ((w % 2) == 0);
  endfunction

endpackage

// File: rtl/sqrt_iter_unit_if.sv
// rtl/sqrt_iter_unit_if.sv - start/valid handshake bundle between host and square-root unit
interface sqrt_iter_unit_if #(
  parameter int WIDTH = 16
);
  localparam int RW = WIDTH / 2;

  logic             start_i;
  logic             abort_i;
  logic [WIDTH-1:0] radicand_i;
  logic             ready_o;
  logic             busy_o;
  logic             valid_o;
  logic [RW-1:0]    root_o;
  logic [RW:0]      rem_o;

  modport master (
    output start_i, abort_i, radicand_i,
    input  ready_o, busy_o, valid_o, root_o, rem_o
  );

  modport slave (
    input  start_i, abort_i, radicand_i,
    output ready_o, busy_o, valid_o, root_o, rem_o
  );

endinterface

// File: rtl/sqrt_iter_unit_step.sv
// rtl/sqrt_iter_unit_step.sv - one combinational bit-pair iteration of the digit-by-digit root
module sqrt_step #(
  parameter int RW = 8
) (
  input  logic [RW:0]   rem_i,
  input  logic [RW-1:0] root_i,
  input  logic [1:0]    pair_i,
  output logic [RW:0]   rem_o,
  output logic [RW-1:0] root_o
);

  logic [RW+2:0] r2;
  logic [RW+2:0] t;
  logic [RW+2:0] diff;
  logic [RW:0]   root_ext;
  logic          ge;
  logic          unused_bits;

  // Trial subtraction carried at RW+3 bits so nothing is lost before the compare.
  always_comb begin
    r2       = {rem_i, pair_i};
    t        = {1'b0, root_i, 2'b01};
    ge       = (r2 >= t);
    diff     = ge ? (r2 - t) : r2;
    rem_o    = diff[RW:0];
    root_ext = {root_i, ge};
    root_o   = root_ext[RW-1:0];
  end

  // Upper remainder bits and the shifted-out root bit are always zero.
  assign unused_bits = ^{diff[RW+2:RW+1], root_ext[RW]};

endmodule

// File: rtl/sqrt_iter_unit.sv
// rtl/sqrt_iter_unit.sv - iterative integer square root, one root bit per clock
module sqrt_iter_unit
  import sqrt_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sqrt_iter_unit_if.slave  bus
);

  localparam int RW = WIDTH / 2;
  localparam int CW = $clog2(WIDTH / 2) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RW - 1);

  generate
    if (!sqrt_width_ok(WIDTH)) begin : g_bad_width
      $error("sqrt_iter_unit: WIDTH must be even and >= 2");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [RW-1:0]    root_q, root_d;
  logic [RW:0]      rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [RW:0]      step_rem;
  logic [RW-1:0]    step_root;
  logic             ready;

  sqrt_step #(.RW(RW)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .pair_i (x_q[WIDTH-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start_i) begin
          state_d = ST_CALC;
          x_d     = bus.radicand_i;
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_CALC: begin
        if (bus.abort_i) begin
          state_d = ST_IDLE;
        end else begin
          root_d = step_root;
          rem_d  = step_rem;
          x_d    = x_q << 2;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status is a pure decode of state so the host never sees an input-to-output path.
  assign bus.ready_o = ready;
  assign bus.busy_o  = (state_q == ST_CALC);
  assign bus.valid_o = (state_q == ST_DONE);
  assign bus.root_o  = root_q;
  assign bus.rem_o   = rem_q;

endmodule
